frame_encoder: RTL and testbench

//  Byte-stream framer downstream of the destination packetizer's tx_frame output.

---
 rtl/frame_pkg.sv | 30 +++
 rtl/frame_encoder.sv | 164 ++++++++++++++++
 tb/tb_frame_encoder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame_encoder byte-stream framer.
//   - default delimiter / escape byte values
//   - fsm_state_t: framer FSM state encoding
//   - crc8_update(): CRC-8, poly 0x07, MSB first, no reflection, no final xor
package frame_pkg;

  localparam logic [7:0] START_BYTE_DEF = 8'h7E;
  localparam logic [7:0] STOP_BYTE_DEF  = 8'h7F;
  localparam logic [7:0] ESC_BYTE_DEF   = 8'h7D;
  localparam logic [7:0] ESC_XOR_DEF    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    ESC,
    CRC,
    STOP
  } fsm_state_t;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_encoder.sv
// frame_encoder: wraps each AXI4-Stream frame as START, payload, STOP and
// byte-stuffs reserved bytes (START/STOP/ESC) as ESC, byte ^ ESC_XOR.
// Optional feature macro: FRAME_CRC_EN appends an escaped CRC-8 byte before STOP.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   target_tvalid/tready/tlast/tdata      input frame bytes
//   initiator_tvalid/tready/tlast/tdata   encoded stream (tlast only with STOP)
module frame_encoder
  import frame_pkg::*;
#(
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEF,
  parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF,
  parameter logic [7:0] ESC_XOR    = ESC_XOR_DEF
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       target_tvalid,
  output logic       target_tready,
  input  logic       target_tlast,
  input  logic [7:0] target_tdata,
  output logic       initiator_tvalid,
  input  logic       initiator_tready,
  output logic       initiator_tlast,
  output logic [7:0] initiator_tdata
);

  fsm_state_t r_state, w_next;
  logic       r_tvalid, r_tlast, r_last;
  logic [7:0] r_tdata, r_pend;

  logic       w_free, w_in_hs, w_in_special;
  logic       w_load, w_load_last, w_tready, w_pend_load;
  logic [7:0] w_load_data, w_pend_data;
  fsm_state_t w_esc_tail;

`ifdef FRAME_CRC_EN
  logic [7:0] r_crc;
  logic       r_crc_done;
  logic       w_crc_special;
  // TAIL is not a real state: it resolves straight to CRC or STOP.
  localparam fsm_state_t TAIL_NEXT = CRC;
  assign w_crc_special = (r_crc == START_BYTE) || (r_crc == STOP_BYTE) ||
                         (r_crc == ESC_BYTE);
  // The CRC byte reuses the ESC/pend path with r_last set, so r_crc_done
  // tells ESC whether the CRC is still owed or STOP comes next.
  assign w_esc_tail = r_crc_done ? STOP : CRC;
`else
  localparam fsm_state_t TAIL_NEXT = STOP;
  assign w_esc_tail = STOP;
`endif

  assign w_free       = !r_tvalid || initiator_tready;
  assign w_in_hs      = (r_state == DATA) && target_tvalid && w_free;
  assign w_in_special = (target_tdata == START_BYTE) ||
                        (target_tdata == STOP_BYTE) ||
                        (target_tdata == ESC_BYTE);

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    w_tready    = 1'b0;
    w_pend_load = 1'b0;
    w_pend_data = target_tdata ^ ESC_XOR;
    case (r_state)
      IDLE: begin
        if (target_tvalid && w_free) begin
          w_load      = 1'b1;
          w_load_data = START_BYTE;
          w_next      = DATA;
        end
      end
      DATA: begin
        w_tready = w_free;
        if (w_in_hs) begin
          w_load = 1'b1;
          if (w_in_special) begin
            w_load_data = ESC_BYTE;
            w_pend_load = 1'b1;
            w_next      = ESC;
          end else begin
            w_load_data = target_tdata;
            if (target_tlast) w_next = TAIL_NEXT;
          end
        end
      end
      ESC: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_data = r_pend;
          w_next      = r_last ? w_esc_tail : DATA;
        end
      end
`ifdef FRAME_CRC_EN
      CRC: begin
        if (w_free) begin
          w_load = 1'b1;
          if (w_crc_special) begin
            w_load_data = ESC_BYTE;
            w_pend_load = 1'b1;
            w_pend_data = r_crc ^ ESC_XOR;
            w_next      = ESC;
          end else begin
            w_load_data = r_crc;
            w_next      = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_data = STOP_BYTE;
          w_load_last = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= IDLE;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_pend   <= '0;
      r_last   <= 1'b0;
`ifdef FRAME_CRC_EN
      r_crc      <= '0;
      r_crc_done <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_free) begin
        r_tvalid <= w_load;
        r_tlast  <= w_load_last;
        if (w_load) r_tdata <= w_load_data;
      end
      if (w_pend_load) r_pend <= w_pend_data;
      if (w_in_hs && target_tlast) r_last <= 1'b1;
      else if (r_state == STOP && w_free) r_last <= 1'b0;
`ifdef FRAME_CRC_EN
      if (r_state == IDLE && w_load) begin
        r_crc      <= '0;
        r_crc_done <= 1'b0;
      end else if (w_in_hs) begin
        r_crc <= crc8_update(r_crc, target_tdata);
      end else if (r_state == CRC && w_free) begin
        r_crc_done <= 1'b1;
      end
`endif
    end
  end

  assign target_tready    = w_tready;
  assign initiator_tvalid = r_tvalid;
  assign initiator_tlast  = r_tlast;
  assign initiator_tdata  = r_tdata;

endmodule

// File: tb/tb_frame_encoder.sv
// tb_frame_encoder: directed table of frames with hand-computed encodings,
// random-stall stream with decoder scoreboard, and a mid-frame reset sequence.
module tb_frame_encoder;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       target_tvalid = 1'b0;
  logic       target_tready;
  logic       target_tlast = 1'b0;
  logic [7:0] target_tdata = '0;
  logic       initiator_tvalid;
  logic       initiator_tready = 1'b1;
  logic       initiator_tlast;
  logic [7:0] initiator_tdata;

  frame_encoder dut (
    .aclk            (aclk),
    .areset          (areset),
    .target_tvalid   (target_tvalid),
    .target_tready   (target_tready),
    .target_tlast    (target_tlast),
    .target_tdata    (target_tdata),
    .initiator_tvalid(initiator_tvalid),
    .initiator_tready(initiator_tready),
    .initiator_tlast (initiator_tlast),
    .initiator_tdata (initiator_tdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic [7:0] cap_d[$];
  bit         cap_l[$];
  int         cap_c[$];

  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  bit         prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always @(posedge aclk) cyc++;

  // Handshake monitor and stall-stability checks, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, initiator_tvalid}, 32'd1);
        chk("stall_data", {24'd0, initiator_tdata}, {24'd0, prev_data});
        chk("stall_last", {31'd0, initiator_tlast}, {31'd0, prev_last});
      end
      if (initiator_tvalid && !initiator_tready)
        chk("stall_in_ready", {31'd0, target_tready}, 32'd0);
      if (initiator_tvalid && initiator_tready) begin
        cap_d.push_back(initiator_tdata);
        cap_l.push_back(initiator_tlast);
        cap_c.push_back(cyc);
      end
      prev_stall = initiator_tvalid && !initiator_tready;
      prev_data  = initiator_tdata;
      prev_last  = initiator_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) initiator_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] d, input bit l);
    int t;
    target_tvalid = 1'b1;
    target_tdata  = d;
    target_tlast  = l;
    t = 0;
    @(negedge aclk);
    while (!target_tready && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 500) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
  endtask

  task automatic wait_caps(input int n);
    int t;
    t = 0;
    while (cap_d.size() < n && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    repeat (4) @(posedge aclk);
    #1;
  endtask

  typedef struct {
    int           n_in;
    logic [63:0]  in_b;
    logic [7:0]   in_last;
    int           n_out;
    logic [127:0] out_b;
    logic [15:0]  out_last;
  } vec_t;

  vec_t vecs[5];
  int   nvec;

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] dec_q[$];
    logic [7:0] fr[$];
    bit in_frame, esc;
    logic [7:0] d;

`ifdef FRAME_CRC_EN
    vecs[0] = '{2, 64'h0102,   8'b01,  5, 128'h7E01021B7F,       16'b00001};
    vecs[1] = '{1, 64'h12,     8'b1,   5, 128'h7E127D5E7F,       16'b00001};
    vecs[2] = '{3, 64'h010203, 8'b001, 6, 128'h7E01020348_7F,    16'b000001};
    vecs[3] = '{2, 64'hAABB,   8'b11,  8, 128'h7EAA5F7F7EBB287F, 16'b00010001};
    nvec = 4;
`else
    vecs[0] = '{3, 64'h010203,   8'b001,  5, 128'h7E0102037F,       16'b00001};
    vecs[1] = '{3, 64'h7E7D7F,   8'b001,  8, 128'h7E7D5E7D5D7D5F7F, 16'b00000001};
    vecs[2] = '{2, 64'hAABB,     8'b11,   6, 128'h7EAA7F7EBB7F,     16'b001001};
    vecs[3] = '{4, 64'h00FF5E7C, 8'b0001, 6, 128'h7E00FF5E7C7F,     16'b000001};
    vecs[4] = '{1, 64'h7D,       8'b1,    4, 128'h7E7D5D7F,         16'b0001};
    nvec = 5;
`endif

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_out_valid", {31'd0, initiator_tvalid}, 32'd0);
    chk("rst_out_last", {31'd0, initiator_tlast}, 32'd0);
    chk("rst_out_data", {24'd0, initiator_tdata}, 32'd0);
    chk("rst_in_ready", {31'd0, target_tready}, 32'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Directed table, output ready held high: exact bytes, tlast, back-to-back timing.
    for (int v = 0; v < nvec; v++) begin
      cap_d.delete(); cap_l.delete(); cap_c.delete();
      for (int i = 0; i < vecs[v].n_in; i++)
        send_byte(vecs[v].in_b[8*(vecs[v].n_in-1-i) +: 8], vecs[v].in_last[vecs[v].n_in-1-i]);
      wait_caps(vecs[v].n_out);
      chk($sformatf("v%0d_count", v), cap_d.size(), vecs[v].n_out);
      for (int i = 0; i < vecs[v].n_out && i < cap_d.size(); i++) begin
        chk($sformatf("v%0d_byte%0d", v, i), {24'd0, cap_d[i]},
            {24'd0, vecs[v].out_b[8*(vecs[v].n_out-1-i) +: 8]});
        chk($sformatf("v%0d_last%0d", v, i), {31'd0, cap_l[i]},
            {31'd0, vecs[v].out_last[vecs[v].n_out-1-i]});
      end
      if (cap_c.size() == vecs[v].n_out)
        chk($sformatf("v%0d_contiguous", v), cap_c[vecs[v].n_out-1] - cap_c[0],
            vecs[v].n_out - 1);
    end

    // Random stalls on 64-byte frames with a decoding scoreboard.
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(0, 5))
          0: d = 8'h7E;
          1: d = 8'h7D;
          2: d = 8'h7F;
          default: d = 8'($urandom_range(0, 255));
        endcase
        exp_q.push_back(d);
        send_byte(d, i == 63);
      end
    end
    begin
      int t = 0;
      int stops;
      stops = 0;
      while (stops < 3 && t < 5000) begin
        @(posedge aclk);
        t++;
        stops = 0;
        foreach (cap_l[k]) if (cap_l[k]) stops++;
      end
      chk("rand_stops", stops, 3);
    end
    rand_ready = 1'b0;
    @(posedge aclk);
    #2;
    initiator_tready = 1'b1;

    in_frame = 1'b0;
    esc = 1'b0;
    dec_q.delete();
    foreach (cap_d[k]) begin
      d = cap_d[k];
      chk("rand_tlast_on_stop", {31'd0, cap_l[k]}, {31'd0, (d == 8'h7F && !esc)});
      if (!in_frame) begin
        chk("rand_start", {24'd0, d}, 32'h7E);
        in_frame = 1'b1;
        fr.delete();
      end else if (esc) begin
        fr.push_back(d ^ 8'h20);
        esc = 1'b0;
      end else if (d == 8'h7D) begin
        esc = 1'b1;
      end else if (d == 8'h7F) begin
        in_frame = 1'b0;
`ifdef FRAME_CRC_EN
        begin
          logic [7:0] c, got;
          got = fr.pop_back();
          c = '0;
          foreach (fr[j]) c = ref_crc(c, fr[j]);
          chk("rand_crc", {24'd0, got}, {24'd0, c});
        end
`endif
        foreach (fr[j]) dec_q.push_back(fr[j]);
      end else begin
        fr.push_back(d);
      end
    end
    chk("rand_len", dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
      chk($sformatf("rand_byte%0d", i), {24'd0, dec_q[i]}, {24'd0, exp_q[i]});

    // Reset mid-payload: frame dropped, outputs idle next cycle, clean restart.
    target_tvalid = 1'b1;
    target_tdata  = 8'h11;
    target_tlast  = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b1;
    target_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    chk("midrst_out_valid", {31'd0, initiator_tvalid}, 32'd0);
    chk("midrst_in_ready", {31'd0, target_tready}, 32'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    send_byte(8'h01, 1'b1);
`ifdef FRAME_CRC_EN
    wait_caps(4);
    chk("postrst_count", cap_d.size(), 4);
`else
    wait_caps(3);
    chk("postrst_count", cap_d.size(), 3);
`endif
    if (cap_d.size() >= 2) begin
      chk("postrst_start", {24'd0, cap_d[0]}, 32'h7E);
      chk("postrst_payload", {24'd0, cap_d[1]}, 32'h01);
      chk("postrst_stop", {24'd0, cap_d[cap_d.size()-1]}, 32'h7F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
